// File: rtl/bit_alu_slice.sv
// N-bit ripple-carry ALU: replicated one-bit slices (full adder with B-invert, 8:1 result mux).
// One cycle from inputs to registered outputs; new inputs are accepted every cycle, no backpressure.

module bit_alu_bit (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  input  logic [2:0] en_i,
  output logic       res_o,
  output logic       c_o
);

  logic b_eff;
  logic sum;

  always_comb begin
    b_eff = b_i ^ en_i[0];
    sum   = a_i ^ b_eff ^ c_i;
    c_o   = (a_i & b_eff) | (a_i & c_i) | (b_eff & c_i);
    res_o = 1'b0;
    case (en_i)
      3'b000:         res_o = b_i;
      3'b010, 3'b011: res_o = sum;
      3'b100:         res_o = a_i & b_i;
      3'b101:         res_o = a_i | b_i;
      3'b110:         res_o = a_i ^ b_i;
      default:        res_o = 1'b0;
    endcase
  end

endmodule

module bit_alu_slice #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       en,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] res_d;
  logic             is_arith;
  logic             cout_d;
  logic             zero_d;
  logic             negative_d;
  logic             overflow_d;

  logic [WIDTH-1:0] out_q;
  logic             cout_q;
  logic             zero_q;
  logic             negative_q;
  logic             overflow_q;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    bit_alu_bit u_bit (
      .a_i   (a[i]),
      .b_i   (b[i]),
      .c_i   (carry[i]),
      .en_i  (en),
      .res_o (res_d[i]),
      .c_o   (carry[i+1])
    );
  end

  // Carry chain always runs; only add/sub give cout and overflow a meaning.
  always_comb begin
    is_arith   = (en == 3'b010) || (en == 3'b011);
    cout_d     = carry[WIDTH];
    zero_d     = ~|res_d;
    negative_d = res_d[WIDTH-1];
    overflow_d = is_arith ? (carry[WIDTH-1] ^ carry[WIDTH]) : 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q      <= '0;
      cout_q     <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      out_q      <= res_d;
      cout_q     <= cout_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      overflow_q <= overflow_d;
    end
  end

  assign out      = out_q;
  assign cout     = cout_q;
  assign zero     = zero_q;
  assign negative = negative_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bit_alu_slice.sv
// Directed bench for bit_alu_slice at WIDTH=1 and WIDTH=8 with hand-computed expectations.
module tb_bit_alu_slice;

  logic       clk;
  logic       reset;
  logic       cin;
  logic [2:0] en;
  logic       a1, b1;
  logic [7:0] a8, b8;

  logic       out1, cout1, zero1, neg1, ovf1;
  logic [7:0] out8;
  logic       cout8, zero8, neg8, ovf8;

  int total;
  int bad;

  bit_alu_slice #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .a(a1), .b(b1), .cin(cin), .en(en),
    .out(out1), .cout(cout1), .zero(zero1), .negative(neg1), .overflow(ovf1)
  );

  bit_alu_slice #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .a(a8), .b(b8), .cin(cin), .en(en),
    .out(out8), .cout(cout8), .zero(zero8), .negative(neg8), .overflow(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; cin = 1'b0; en = 3'b000; a1 = 1'b0; b1 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    #2;
    total++;
    if ({out1, cout1, zero1, neg1, ovf1} !== 5'b0 || {out8, cout8, zero8, neg8, ovf8} !== 12'h0) begin
      bad++;
      $display("FAIL reset_async w1=%b w8=%h_%b want all zero", {out1, cout1, zero1, neg1, ovf1}, out8, {cout8, zero8, neg8, ovf8});
    end
    @(posedge clk); #1;
    total++;
    if ({out1, cout1, zero1, neg1, ovf1} !== 5'b0 || {out8, cout8, zero8, neg8, ovf8} !== 12'h0) begin
      bad++;
      $display("FAIL reset_hold w1=%b w8=%h_%b want all zero", {out1, cout1, zero1, neg1, ovf1}, out8, {cout8, zero8, neg8, ovf8});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add_w1();
    logic [1:0] tab [8];
    tab[0] = 2'b00; tab[1] = 2'b10; tab[2] = 2'b10; tab[3] = 2'b01;
    tab[4] = 2'b10; tab[5] = 2'b01; tab[6] = 2'b01; tab[7] = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      en = 3'b010; a1 = i[2]; b1 = i[1]; cin = i[0];
      @(posedge clk); #1;
      total++;
      if ({out1, cout1} !== tab[i]) begin
        bad++;
        $display("FAIL add_w1 abc=%0d got out,cout=%b want %b", i, {out1, cout1}, tab[i]);
      end
    end
  endtask

  task automatic test_sub_w1();
    @(negedge clk); en = 3'b011; cin = 1'b1; a1 = 1'b1; b1 = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({out1, cout1} !== 2'b11) begin bad++; $display("FAIL sub_w1_10 got %b want 11", {out1, cout1}); end
    @(negedge clk); a1 = 1'b0; b1 = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({out1, cout1} !== 2'b10) begin bad++; $display("FAIL sub_w1_01 got %b want 10", {out1, cout1}); end
    @(negedge clk); a1 = 1'b1; b1 = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({out1, cout1, zero1} !== 3'b011) begin bad++; $display("FAIL sub_w1_11 out,cout,zero got %b want 011", {out1, cout1, zero1}); end
  endtask

  task automatic test_logic_w1();
    logic [2:0] codes [6];
    logic       exp10 [6];
    logic       exp01 [6];
    codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b100;
    codes[3] = 3'b101; codes[4] = 3'b110; codes[5] = 3'b111;
    exp10[0] = 0; exp10[1] = 0; exp10[2] = 0; exp10[3] = 1; exp10[4] = 1; exp10[5] = 0;
    exp01[0] = 1; exp01[1] = 0; exp01[2] = 0; exp01[3] = 1; exp01[4] = 1; exp01[5] = 0;
    cin = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); en = codes[i]; a1 = 1'b1; b1 = 1'b0;
      @(posedge clk); #1;
      total++;
      if (out1 !== exp10[i] || ovf1 !== 1'b0) begin
        bad++;
        $display("FAIL logic_w1_a1b0 en=%b got out=%b ovf=%b want out=%b ovf=0", codes[i], out1, ovf1, exp10[i]);
      end
      @(negedge clk); a1 = 1'b0; b1 = 1'b1;
      @(posedge clk); #1;
      total++;
      if (out1 !== exp01[i] || zero1 !== ~exp01[i]) begin
        bad++;
        $display("FAIL logic_w1_a0b1 en=%b got out=%b zero=%b want out=%b", codes[i], out1, zero1, exp01[i]);
      end
    end
  endtask

  task automatic test_arith_w8();
    @(negedge clk); en = 3'b010; cin = 1'b0; a8 = 8'h7F; b8 = 8'h01;
    @(posedge clk); #1;
    total++;
    if ({out8, cout8, zero8, neg8, ovf8} !== {8'h80, 4'b0011}) begin
      bad++; $display("FAIL add_w8_7f01 got out=%h c,z,n,v=%b want 80 0011", out8, {cout8, zero8, neg8, ovf8});
    end
    // back-to-back: next vector on the very next cycle
    @(negedge clk); a8 = 8'hFF; b8 = 8'h01;
    @(posedge clk); #1;
    total++;
    if ({out8, cout8, zero8, neg8, ovf8} !== {8'h00, 4'b1100}) begin
      bad++; $display("FAIL add_w8_ff01 got out=%h c,z,n,v=%b want 00 1100", out8, {cout8, zero8, neg8, ovf8});
    end
    @(negedge clk); en = 3'b011; cin = 1'b1; a8 = 8'h80; b8 = 8'h01;
    @(posedge clk); #1;
    total++;
    if ({out8, cout8, zero8, neg8, ovf8} !== {8'h7F, 4'b1001}) begin
      bad++; $display("FAIL sub_w8_8001 got out=%h c,z,n,v=%b want 7f 1001", out8, {cout8, zero8, neg8, ovf8});
    end
    @(negedge clk); en = 3'b100; cin = 1'b0; a8 = 8'hFF; b8 = 8'h01;
    @(posedge clk); #1;
    total++;
    if ({out8, cout8, zero8, neg8, ovf8} !== {8'h01, 4'b1000}) begin
      bad++; $display("FAIL and_w8_carry got out=%h c,z,n,v=%b want 01 1000", out8, {cout8, zero8, neg8, ovf8});
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); en = 3'b010; cin = 1'b0; a8 = 8'h7F; b8 = 8'h01;
    @(posedge clk); #1;
    total++;
    if (out8 !== 8'h80) begin bad++; $display("FAIL mid_pre got out=%h want 80", out8); end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({out8, cout8, zero8, neg8, ovf8} !== 12'h0) begin
      bad++; $display("FAIL mid_async got out=%h c,z,n,v=%b want 00 0000", out8, {cout8, zero8, neg8, ovf8});
    end
    a8 = 8'hFF; b8 = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out8, cout8, zero8, neg8, ovf8} !== 12'h0) begin
      bad++; $display("FAIL mid_hold got out=%h c,z,n,v=%b want 00 0000", out8, {cout8, zero8, neg8, ovf8});
    end
    @(negedge clk); reset = 1'b0; en = 3'b100; a8 = 8'hF0; b8 = 8'h3C;
    @(posedge clk); #1;
    total++;
    if ({out8, zero8, neg8, ovf8} !== {8'h30, 3'b000}) begin
      bad++; $display("FAIL mid_release got out=%h z,n,v=%b want 30 000", out8, {zero8, neg8, ovf8});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add_w1();
    test_sub_w1();
    test_logic_w1();
    test_arith_w8();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_alu_slice.md
Name: bit_alu_slice

Overview:
- N-bit ALU built from replicated one-bit slices; each slice contains a full adder with a B-invert control and an 8:1 result multiplexer.
- Bit ripple carry chains slice carry-out to the next slice's carry-in.
- Outputs are registered once; the block is the per-bit datapath element of the processor ALU.

Parameters:
- WIDTH, 1, number of bit slices (operand width); legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset; clears all registered outputs.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- en  input  3  operation select, decoded below.
- out  output  WIDTH  registered result.
- cout  output  1  registered carry-out of the MSB adder.
- zero  output  1  registered; 1 when the result is all zeros.
- negative  output  1  registered copy of result MSB.
- overflow  output  1  registered signed overflow; meaningful for add/sub only.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset asserted: out, cout, zero, negative and overflow all go to 0 immediately, with no clock edge required. They hold 0 while reset is high.
- Reset release: the first rising clk edge after release captures the current inputs.
- Each bit uses an adder input of b_eff = b XOR en[0]. The adder produces sum = a XOR b_eff XOR c_in and c_out = majority(a, b_eff, c_in).
- Bit 0 carry-in is cin. Bit i carry-in is the carry-out of bit i-1.
- Per-bit result selected by en:
  - 000: b (pass B)
  - 001: 0
  - 010: adder sum (A + B + cin)
  - 011: adder sum with B inverted (A + ~B + cin; cin=1 gives A-B)
  - 100: a AND b
  - 101: a OR b
  - 110: a XOR b
  - 111: 0
- Carry, zero and overflow:
  - Carry chain is evaluated for every en value. cout is the MSB adder carry-out regardless of the selected operation; only 010/011 make it meaningful.
  - zero = NOR of all result bits.
  - overflow = carry into MSB XOR carry out of MSB, for en 010/011; forced 0 for all other codes.
- Latency: exactly 1 clk cycle from input change to registered output. No handshake; new inputs are accepted every cycle.
- Datapath is purely combinational up to the output register. No internal state other than the output flops.
- X/undefined en values are not supported. All 8 codes are defined.

Test Plan:
- WIDTH=1, en=010: sweep all 8 combinations of {a,b,cin} -> {out,cout} = 000→0,0; 001→1,0; 010→1,0; 011→0,1; 100→1,0; 101→0,1; 110→0,1; 111→1,1, one cycle after apply.
- WIDTH=1, en=011, cin=1: a=1,b=0 → out=1,cout=1; a=0,b=1 → out=1,cout=0; a=1,b=1 → out=0,cout=1, zero=1.
- WIDTH=1, a=1,b=0: en=000→0, 001→0, 100→0, 101→1, 110→1, 111→0; repeat with a=0,b=1 → 1,0,0,1,1,0.
- WIDTH=8, en=010, cin=0: a=0x7F,b=0x01 → out=0x80, cout=0, negative=1, overflow=1; a=0xFF,b=0x01 → out=0x00, cout=1, zero=1, overflow=0.
- WIDTH=8: assert reset mid-stream with out=0x80 → all outputs 0 before the next clk edge and held while reset is high. After release, the first edge with en=100,a=0xF0,b=0x3C → out=0x30.
